// File: rtl/regfile_port_sequencer.sv
// regfile_port_sequencer: owns the register file write port and read port 1.
// It arbitrates CPU writebacks against host writes, with a bounded host wait.
// It also runs the CLEAR (zero every register) and DUMP (stream every register)
// maintenance sequences, stalling the core while either one runs.
module regfile_port_sequencer #(
    parameter int MAX_WAIT = 4,
    parameter int DW       = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cpu_we,
    input  logic [4:0]    cpu_waddr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [4:0]    cpu_a1,
    output logic          cpu_stall,
    input  logic          host_valid,
    input  logic [4:0]    host_waddr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ready,
    input  logic          clear_start,
    input  logic          dump_start,
    output logic          busy,
    output logic          clear_done,
    output logic          dump_done,
    output logic          dump_valid,
    output logic [4:0]    dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          rf_we,
    output logic [4:0]    rf_a3,
    output logic [DW-1:0] rf_wd,
    output logic [4:0]    rf_a1,
    input  logic [DW-1:0] rf_rd1
);

    localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DUMP} state_t;

    state_t         state_q, state_d, state_cur;
    logic [4:0]     idx_q, idx_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d, wait_cur;
    logic           clear_done_q, clear_done_d;
    logic           dump_done_q, dump_done_d;
    logic           wr_req;

    assign clear_done = clear_done_q;
    assign dump_done  = dump_done_q;

    // Port muxing; while RST is high the outputs follow the IDLE rules so an aborted sequence writes nothing more
    always_comb begin
        state_cur  = RST ? S_IDLE : state_q;
        wait_cur   = RST ? '0 : wait_cnt_q;
        cpu_stall  = 1'b0;
        host_ready = 1'b0;
        busy       = 1'b0;
        wr_req     = 1'b0;
        rf_we      = 1'b0;
        rf_a3      = cpu_waddr;
        rf_wd      = cpu_wdata;
        rf_a1      = cpu_a1;
        dump_valid = 1'b0;
        dump_addr  = idx_q;
        dump_data  = rf_rd1;
        case (state_cur)
            S_CLEAR: begin
                busy      = 1'b1;
                cpu_stall = 1'b1;
                rf_we     = 1'b1;
                rf_a3     = idx_q;
                rf_wd     = '0;
            end
            S_DUMP: begin
                busy       = 1'b1;
                cpu_stall  = 1'b1;
                rf_a1      = idx_q;
                dump_valid = 1'b1;
            end
            default: begin
                if (host_valid && wait_cur == WAIT_MAX) begin
                    // Host has waited long enough: it takes the port and the core stalls once
                    host_ready = 1'b1;
                    cpu_stall  = 1'b1;
                    wr_req     = 1'b1;
                    rf_a3      = host_waddr;
                    rf_wd      = host_wdata;
                end else if (cpu_we) begin
                    wr_req = 1'b1;
                end else begin
                    host_ready = 1'b1;
                    wr_req     = host_valid;
                    rf_a3      = host_waddr;
                    rf_wd      = host_wdata;
                end
                // $zero is hard-wired: accept the write but never let it land
                rf_we = wr_req && (rf_a3 != 5'd0);
            end
        endcase
    end

    // Next-state logic for the sequencer, index, host wait counter and done pulses
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wait_cnt_d   = wait_cnt_q;
        clear_done_d = 1'b0;
        dump_done_d  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                idx_d = idx_q + 5'd1;
                if (idx_q == 5'd31) begin
                    state_d      = S_IDLE;
                    clear_done_d = 1'b1;
                end
            end
            S_DUMP: begin
                idx_d = idx_q + 5'd1;
                if (idx_q == 5'd31) begin
                    state_d     = S_IDLE;
                    dump_done_d = 1'b1;
                end
            end
            default: begin
                if (!host_valid || host_ready) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
                if (clear_start) begin
                    state_d = S_CLEAR;
                    idx_d   = 5'd0;
                end else if (dump_start) begin
                    state_d = S_DUMP;
                    idx_d   = 5'd0;
                end
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            idx_q        <= 5'd0;
            wait_cnt_q   <= '0;
            clear_done_q <= 1'b0;
            dump_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wait_cnt_q   <= wait_cnt_d;
            clear_done_q <= clear_done_d;
            dump_done_q  <= dump_done_d;
        end
    end

endmodule

// File: doc/regfile_port_sequencer.md
# regfile_port_sequencer

Arbiter and sequencer for the 32x32 register file's write port and first read port. It sits between the single-cycle core, a host/debug write channel and the register file. It forwards CPU writebacks, grants host writes with bounded wait, and runs two multi-cycle maintenance sequences while stalling the core: CLEAR (zero all registers) and DUMP (stream all registers out).

## Interface
- MAX_WAIT, 4: consecutive blocked host cycles before a host write is forced ahead of the CPU (0 = host always wins).
- DW, 32: data width.
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- cpu_we / cpu_waddr / cpu_wdata  in  1 / 5 / DW  CPU writeback request.
- cpu_a1  in  5  CPU read-port-1 address.
- cpu_stall  out  1  combinational; core must hold PC and repeat its writeback next cycle.
- host_valid / host_waddr / host_wdata  in  1 / 5 / DW  host write request; payload held stable until accepted.
- host_ready  out  1  combinational; a write is accepted on a cycle with host_valid && host_ready.
- clear_start, dump_start  in  1  single-cycle command pulses.
- busy  out  1  high in CLEAR or DUMP.
- clear_done, dump_done  out  1  registered one-cycle completion pulses.
- dump_valid / dump_addr / dump_data  out  1 / 5 / DW  dump stream.
- rf_we / rf_a3 / rf_wd  out  1 / 5 / DW  to register file WE3/A3/WD3.
- rf_a1  out  5  to register file A1.
- rf_rd1  in  DW  register file RD1, asynchronous read data.

## Operation
- States: IDLE, CLEAR, DUMP. The state register, 5-bit index idx, wait_cnt and the done pulses are registered. All rf_* outputs, cpu_stall and host_ready are combinational from state and inputs.
- IDLE:
  - rf_a1 = cpu_a1. busy = 0.
  - Forced grant when host_valid && wait_cnt == MAX_WAIT: host_ready = 1, cpu_stall = 1, and the host write drives the port.
  - Otherwise, if cpu_we: the CPU drives the port, host_ready = 0, cpu_stall = 0.
  - Otherwise: host_ready = 1, and a valid host write drives the port.
  - wait_cnt increments when host_valid && !host_ready. It clears on host acceptance or when host_valid = 0. It saturates at MAX_WAIT.
- Writes to address 0 ($zero), from the CPU or the host, are accepted but suppressed: rf_we = 0.
- Commands: accepted only in IDLE. Simultaneous clear_start and dump_start means CLEAR wins and dump_start is dropped. Either command moves the state to CLEAR or DUMP with idx = 0. A host write accepted in the same cycle still completes. Commands while busy are ignored.
- CLEAR:
  - Each cycle: rf_we = 1, rf_a3 = idx, rf_wd = 0, idx++.
  - Writes go to all 32 registers, including 0.
  - After the idx = 31 write: return to IDLE, clear_done = 1 for the next cycle.
- DUMP:
  - Each cycle: rf_a1 = idx, dump_valid = 1, dump_addr = idx, dump_data = rf_rd1, rf_we = 0, idx++.
  - After idx = 31: return to IDLE, dump_done = 1 for the next cycle.
- In CLEAR and DUMP: cpu_stall = 1, host_ready = 0, and cpu_we is ignored (not lost; the core repeats it). wait_cnt holds.
- dump_valid is 0 outside DUMP. dump_addr and dump_data are don't-care when dump_valid = 0.

## Timing
- Reset values:
  - State IDLE; idx = 0; wait_cnt = 0.
  - clear_done = dump_done = busy = dump_valid = 0.
  - rf_we follows the IDLE rules combinationally.
- RST in mid-CLEAR or mid-DUMP aborts the sequence. No done pulse is issued, and registers already cleared stay cleared.
- Write latency: a granted write lands at the rising edge ending the grant cycle.
- Sequence length:
  - The command is accepted at edge N.
  - Sequence cycles run N+1 .. N+32, with busy high in exactly those 32 cycles.
  - The done pulse is high in cycle N+33, which is IDLE.
- Host worst-case wait with cpu_we held high: blocked for MAX_WAIT cycles, accepted in cycle MAX_WAIT+1. Exactly one stall cycle per forced grant.
- A new command may be accepted in the same cycle the done pulse is high.

## Test plan
- CPU write: cpu_we = 1, waddr = 5, wdata = 0xDEADBEEF, host idle.
  - Required: rf_we = 1, rf_a3 = 5, cpu_stall = 0, reg 5 = 0xDEADBEEF next cycle.
  - Then waddr = 0: rf_we = 0.
- Starvation, MAX_WAIT = 4: cpu_we held high, host_valid from cycle 0 with waddr = 7, wdata = 0x12.
  - Required: host_ready low in cycles 0-3.
  - Cycle 4: host_ready = 1, cpu_stall = 1, rf_a3 = 7.
  - Cycle 5: CPU write resumes and wait_cnt = 0.
- CLEAR: preload registers with nonzero values, pulse clear_start.
  - Required: busy high for 32 cycles, rf_a3 steps 0..31 with rf_wd = 0, cpu_stall = 1 throughout.
  - clear_done pulses once, then all registers read 0.
- DUMP: preload reg i = i*3, pulse dump_start.
  - Required: 32 dump_valid cycles with dump_addr = i and dump_data = i*3, no rf_we.
  - Then dump_done.
- Simultaneous clear_start and dump_start in IDLE: CLEAR runs and no dump_valid is ever seen. A dump_start during CLEAR is ignored.
- RST asserted at CLEAR idx = 10: next cycle IDLE, busy = 0, no clear_done, registers 0-9 = 0, registers 10-31 unchanged.
